// File: rtl/pkt_pkg.sv
// pkt_pkg: shared packet definitions for the per-direction router input buffer.
//   PKT_ID_W / PKT_FLIT_W : field widths of a stored packet
//   QOS_HI / QOS_LO       : QoS class encodings carried in the qos field
//   pkt_t                 : packed packet record stored in each QoS queue
package pkt_pkg;

   localparam int PKT_ID_W   = 6;
   localparam int PKT_FLIT_W = 8;

   localparam logic QOS_HI = 1'b1;
   localparam logic QOS_LO = 1'b0;

   typedef struct packed {
      logic                  qos;
      logic [1:0]            pkt_type;
      logic [PKT_ID_W-1:0]   src;
      logic [PKT_ID_W-1:0]   tgt;
      logic [PKT_FLIT_W-1:0] data;
   } pkt_t;

endpackage

// File: rtl/pkt_in_buf_if.sv
// pkt_in_buf_if: upstream/downstream handshake bundle of one input buffer.
//   in_*    : packet offered by the link interface (vld/rdy)
//   out_*   : head packet presented to the route/crossbar stage (vld/rdy)
//   hi_cnt, lo_cnt : queue occupancy
// master = the surrounding router logic, slave = the buffer.
interface pkt_in_buf_if #(
   parameter int ID_W   = 6,
   parameter int FLIT_W = 8,
   parameter int CNT_W  = 3
);
   logic              in_vld;
   logic              in_rdy;
   logic              in_qos;
   logic [1:0]        in_type;
   logic [ID_W-1:0]   in_src;
   logic [ID_W-1:0]   in_tgt;
   logic [FLIT_W-1:0] in_data;

   logic              out_vld;
   logic              out_rdy;
   logic              out_qos;
   logic [1:0]        out_type;
   logic [ID_W-1:0]   out_src;
   logic [ID_W-1:0]   out_tgt;
   logic [FLIT_W-1:0] out_data;

   logic [CNT_W-1:0]  hi_cnt;
   logic [CNT_W-1:0]  lo_cnt;

   modport master (
      output in_vld, in_qos, in_type, in_src, in_tgt, in_data, out_rdy,
      input  in_rdy, out_vld, out_qos, out_type, out_src, out_tgt, out_data,
             hi_cnt, lo_cnt
   );

   modport slave (
      input  in_vld, in_qos, in_type, in_src, in_tgt, in_data, out_rdy,
      output in_rdy, out_vld, out_qos, out_type, out_src, out_tgt, out_data,
             hi_cnt, lo_cnt
   );
endinterface

// File: rtl/pkt_fifo.sv
// pkt_fifo: synchronous FIFO of pkt_t, one per QoS class.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write din at the tail
//   pop        : drop the head entry
//   head       : current head entry (meaningful only when count != 0)
//   count      : registered occupancy
// The caller never pushes when full or pops when empty; full/empty live in
// the count, the pointers simply wrap modulo DEPTH.
module pkt_fifo
   import pkt_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  pkt_t             din,
   input  logic             pop,
   output pkt_t             head,
   output logic [CNT_W-1:0] count
);

   pkt_t             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: entries are only read once counted in
   always_ff @(posedge clk) begin
      if (push && !rst) mem_q[wr_ptr_q] <= din;
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/pkt_in_buf.sv
// pkt_in_buf: per-direction input buffer of a mesh router node.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pkt_in_buf_if.slave
//              in_*  packet accept handshake, steered by in_qos into hi/lo queue
//              out_* head packet, hi first with a bounded starvation guard for lo
//              hi_cnt/lo_cnt registered queue occupancy
//
// Presentation state:
//   hold_q | sel_hi_q | meaning
//   -------+----------+--------------------------------------------------
//     0    |    x     | free: queue picked fresh each cycle
//     1    |    0     | lo head offered but refused; lo stays selected
//     1    |    1     | hi head offered but refused; hi stays selected
//
// The starvation guard is a down-counting budget: reloaded to STARVE_MAX
// whenever lo is empty or pops, decremented (saturating at 0) on each hi pop
// while lo waits. A zero budget hands the next slot to lo.
module pkt_in_buf
   import pkt_pkg::*;
#(
   parameter int ID_W       = PKT_ID_W,
   parameter int FLIT_W     = PKT_FLIT_W,
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 4
) (
   input logic         clk,
   input logic         rst,
   pkt_in_buf_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int BUD_W = $clog2(STARVE_MAX + 1);

   pkt_t             in_pkt;
   pkt_t             hi_head, lo_head, sel_head;
   logic [CNT_W-1:0] hi_cnt, lo_cnt;
   logic             hi_nempty, lo_nempty;
   logic             in_rdy, out_vld;
   logic             push, pop;
   logic             hi_push, lo_push, hi_pop, lo_pop;
   logic             sel_hi;

   logic             hold_q, hold_d;
   logic             sel_hi_q, sel_hi_d;
   logic [BUD_W-1:0] budget_q, budget_d;

   always_comb begin
      in_pkt          = '0;
      in_pkt.qos      = bus.in_qos;
      in_pkt.pkt_type = bus.in_type;
      in_pkt.src      = bus.in_src;
      in_pkt.tgt      = bus.in_tgt;
      in_pkt.data     = bus.in_data;
   end

   always_comb begin
      hi_nempty = (hi_cnt != '0);
      lo_nempty = (lo_cnt != '0);

      // counts only, so no same-cycle pass-through on a full queue
      in_rdy = !rst && (hi_cnt < CNT_W'(DEPTH)) && (lo_cnt < CNT_W'(DEPTH));

      if (hold_q)                             sel_hi = sel_hi_q;
      else if (hi_nempty && budget_q != '0)   sel_hi = 1'b1;
      else if (lo_nempty)                     sel_hi = 1'b0;
      else                                    sel_hi = 1'b1;

      out_vld = sel_hi ? hi_nempty : lo_nempty;

      push    = bus.in_vld && in_rdy;
      hi_push = push && (bus.in_qos == QOS_HI);
      lo_push = push && (bus.in_qos == QOS_LO);
      pop     = out_vld && bus.out_rdy;
      hi_pop  = pop && sel_hi;
      lo_pop  = pop && !sel_hi;

      sel_head = '0;
      if (out_vld) sel_head = sel_hi ? hi_head : lo_head;
   end

   always_comb begin
      hold_d   = hold_q;
      sel_hi_d = sel_hi;
      if (out_vld && !bus.out_rdy) hold_d = 1'b1;
      else if (pop)                hold_d = 1'b0;

      budget_d = budget_q;
      if (hi_pop && lo_nempty) begin
         if (budget_q != '0) budget_d = budget_q - BUD_W'(1);
      end else if (lo_pop || !lo_nempty) begin
         budget_d = BUD_W'(STARVE_MAX);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q   <= 1'b0;
         sel_hi_q <= 1'b0;
         budget_q <= BUD_W'(STARVE_MAX);
      end else begin
         hold_q   <= hold_d;
         sel_hi_q <= sel_hi_d;
         budget_q <= budget_d;
      end
   end

   pkt_fifo #(.DEPTH(DEPTH)) u_hi_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (hi_push),
      .din   (in_pkt),
      .pop   (hi_pop),
      .head  (hi_head),
      .count (hi_cnt)
   );

   pkt_fifo #(.DEPTH(DEPTH)) u_lo_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (lo_push),
      .din   (in_pkt),
      .pop   (lo_pop),
      .head  (lo_head),
      .count (lo_cnt)
   );

   assign bus.in_rdy   = in_rdy;
   assign bus.out_vld  = out_vld;
   assign bus.out_qos  = sel_head.qos;
   assign bus.out_type = sel_head.pkt_type;
   assign bus.out_src  = ID_W'(sel_head.src);
   assign bus.out_tgt  = ID_W'(sel_head.tgt);
   assign bus.out_data = FLIT_W'(sel_head.data);
   assign bus.hi_cnt   = hi_cnt;
   assign bus.lo_cnt   = lo_cnt;

endmodule

// File: tb/tb_pkt_in_buf.sv
// tb_pkt_in_buf: directed scenarios plus random traffic against a queue-based
// reference model of the input buffer.
module tb_pkt_in_buf;
   import pkt_pkg::*;

   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 4;
   localparam int CNT_W      = $clog2(DEPTH + 1);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pkt_in_buf_if #(.ID_W(PKT_ID_W), .FLIT_W(PKT_FLIT_W), .CNT_W(CNT_W)) bus ();

   pkt_in_buf #(
      .ID_W       (PKT_ID_W),
      .FLIT_W     (PKT_FLIT_W),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: two packet queues, an up-counting starvation count,
   // and the held selection
   pkt_t hi_q[$];
   pkt_t lo_q[$];
   int   starve  = 0;
   bit   hold    = 1'b0;
   bit   held_hi = 1'b0;
   bit   pop_log[$];

   function automatic bit m_sel_hi();
      if (hold) return held_hi;
      if (hi_q.size() != 0 && starve < STARVE_MAX) return 1'b1;
      if (lo_q.size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_out_vld();
      return m_sel_hi() ? (hi_q.size() != 0) : (lo_q.size() != 0);
   endfunction

   function automatic pkt_t m_head();
      if (!m_out_vld()) return '0;
      return m_sel_hi() ? hi_q[0] : lo_q[0];
   endfunction

   function automatic bit m_in_rdy();
      return !rst && hi_q.size() < DEPTH && lo_q.size() < DEPTH;
   endfunction

   function automatic pkt_t obs_pkt();
      pkt_t p;
      p.qos      = bus.out_qos;
      p.pkt_type = bus.out_type;
      p.src      = bus.out_src;
      p.tgt      = bus.out_tgt;
      p.data     = bus.out_data;
      return p;
   endfunction

   task automatic drive(input bit v, input bit q, input logic [5:0] s,
                        input logic [5:0] t, input logic [7:0] d, input bit ordy);
      bus.in_vld  = v;
      bus.in_qos  = q;
      bus.in_type = 2'($urandom_range(0, 3));
      bus.in_src  = s;
      bus.in_tgt  = t;
      bus.in_data = d;
      bus.out_rdy = ordy;
   endtask

   // one clock: compare at negedge, advance the model at posedge
   task automatic step();
      bit   v, sh, r, lo_ne;
      pkt_t p;
      @(negedge clk);
      chk("in_rdy",  32'(bus.in_rdy),  32'(m_in_rdy()));
      chk("out_vld", 32'(bus.out_vld), 32'(m_out_vld()));
      chk("out_pkt", 32'(obs_pkt()),   32'(m_head()));
      chk("hi_cnt",  32'(bus.hi_cnt),  32'(hi_q.size()));
      chk("lo_cnt",  32'(bus.lo_cnt),  32'(lo_q.size()));
      if (bus.out_vld && bus.out_rdy && !rst) pop_log.push_back(bus.out_qos);
      v  = m_out_vld();
      sh = m_sel_hi();
      r  = m_in_rdy();
      @(posedge clk);
      if (rst) begin
         hi_q.delete();
         lo_q.delete();
         starve = 0;
         hold   = 1'b0;
      end else begin
         lo_ne = (lo_q.size() != 0);
         if (v && bus.out_rdy) begin
            if (sh) void'(hi_q.pop_front());
            else    void'(lo_q.pop_front());
            if (sh && lo_ne) starve = (starve < STARVE_MAX) ? starve + 1 : starve;
            else             starve = 0;
            hold = 1'b0;
         end else begin
            if (!lo_ne) starve = 0;
            if (v) begin
               hold    = 1'b1;
               held_hi = sh;
            end
         end
         if (r && bus.in_vld) begin
            p.qos      = bus.in_qos;
            p.pkt_type = bus.in_type;
            p.src      = bus.in_src;
            p.tgt      = bus.in_tgt;
            p.data     = bus.in_data;
            if (bus.in_qos) hi_q.push_back(p);
            else            lo_q.push_back(p);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      bit [9:0] pat;
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      step();
      step();
      chk("rst_out_vld", 32'(bus.out_vld), 0);
      chk("rst_hi_cnt",  32'(bus.hi_cnt),  0);
      chk("rst_lo_cnt",  32'(bus.lo_cnt),  0);
      chk("rst_in_rdy",  32'(bus.in_rdy),  0);
      chk("rst_data",    32'(bus.out_data), 0);
      rst = 1'b0;
      #1;
      chk("rdy_after_rst", 32'(bus.in_rdy), 1);

      // single push, next-cycle visibility
      drive(1, 0, 6'd3, 6'd9, 8'hA5, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      chk("lat_vld",  32'(bus.out_vld),  1);
      chk("lat_qos",  32'(bus.out_qos),  0);
      chk("lat_src",  32'(bus.out_src),  3);
      chk("lat_tgt",  32'(bus.out_tgt),  9);
      chk("lat_data", 32'(bus.out_data), 32'hA5);
      step();
      chk("lat_lo_cnt", 32'(bus.lo_cnt), 1);
      bus.out_rdy = 1'b1;
      step();
      chk("lat_popped", 32'(bus.lo_cnt), 0);

      // fill lo, back-pressure, recovery
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 6'(i), 6'(i), 8'(8'h10 + i), 0);
         step();
      end
      chk("full_lo_cnt", 32'(bus.lo_cnt), DEPTH);
      chk("full_in_rdy", 32'(bus.in_rdy), 0);
      drive(1, 0, 6'd7, 6'd7, 8'hEE, 0);
      step();
      chk("full_no_push", 32'(bus.lo_cnt), DEPTH);
      drive(0, 0, 0, 0, 0, 1);
      step();
      chk("full_rdy_back", 32'(bus.in_rdy), 1);
      chk("full_after_pop", 32'(bus.out_data), 32'h11);
      for (int i = 0; i < 4; i++) step();

      // hold: lo presented, hi arrives, lo still goes first
      do_reset();
      drive(1, 0, 6'd1, 6'd2, 8'h3C, 0);
      step();
      drive(1, 1, 6'd4, 6'd5, 8'hC3, 0);
      step();
      drive(0, 0, 0, 0, 0, 0);
      step();
      chk("hold_qos",  32'(bus.out_qos),  0);
      chk("hold_data", 32'(bus.out_data), 32'h3C);
      pop_log.delete();
      bus.out_rdy = 1'b1;
      step();
      step();
      step();
      chk("hold_npop", 32'(pop_log.size()), 2);
      if (pop_log.size() == 2) begin
         chk("hold_first",  32'(pop_log[0]), 0);
         chk("hold_second", 32'(pop_log[1]), 1);
      end

      // starvation guard
      do_reset();
      drive(1, 1, 1, 1, 8'h01, 0); step();
      drive(1, 1, 1, 1, 8'h02, 0); step();
      drive(1, 1, 1, 1, 8'h03, 0); step();
      drive(1, 0, 2, 2, 8'h81, 0); step();
      drive(1, 0, 2, 2, 8'h82, 0); step();
      drive(1, 1, 1, 1, 8'h04, 0); step();
      pop_log.delete();
      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 1, 1, 8'(8'h20 + i), 1);
         step();
      end
      pat = 10'b1111011110;
      chk("starve_npop", 32'(pop_log.size() >= 10), 1);
      for (int i = 0; i < 10; i++)
         if (i < pop_log.size()) chk("starve_order", 32'(pop_log[i]), 32'(pat[9-i]));
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) step();

      // streaming across pointer wrap
      do_reset();
      for (int i = 0; i < 20; i++) begin
         drive(1, 0, 6'd5, 6'd6, 8'(i), 1);
         step();
         chk("stream_vld",  32'(bus.out_vld),  1);
         chk("stream_data", 32'(bus.out_data), 32'(i));
      end
      drive(0, 0, 0, 0, 0, 1);
      step();
      step();

      // reset mid-operation
      do_reset();
      drive(1, 1, 1, 1, 8'h01, 0); step();
      drive(1, 1, 1, 1, 8'h02, 0); step();
      drive(1, 0, 2, 2, 8'h03, 0); step();
      drive(1, 0, 2, 2, 8'h04, 0); step();
      drive(1, 0, 2, 2, 8'h05, 0); step();
      drive(0, 0, 0, 0, 0, 0);
      chk("mid_hi_cnt", 32'(bus.hi_cnt), 2);
      chk("mid_lo_cnt", 32'(bus.lo_cnt), 3);
      rst = 1'b1;
      step();
      chk("mid_out_vld", 32'(bus.out_vld), 0);
      chk("mid_hi_zero", 32'(bus.hi_cnt), 0);
      chk("mid_lo_zero", 32'(bus.lo_cnt), 0);
      rst = 1'b0;
      #1;
      chk("mid_in_rdy", 32'(bus.in_rdy), 1);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
               6'($urandom), 6'($urandom), 8'($urandom), $urandom_range(0, 9) < 6);
         rst = ($urandom_range(0, 63) == 0);
         step();
      end
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) step();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/pkt_in_buf.md
# pkt_in_buf

Per-direction input buffer for a mesh router node. It sits directly downstream of one input port group of the node's link interface (ni_*, wi_*, si_*, ei_*), with one instance per direction. It accepts packets over a vld/rdy handshake and stores them in two QoS-class queues. It presents one packet at a time to the router's route/crossbar stage: high-QoS first, with a bounded starvation guard for low-QoS traffic.

## Interface
Parameters:
- ID_W, 6, width of source/target node ID
- FLIT_W, 8, width of data payload
- DEPTH, 4, entries per QoS queue (power of two, ≥2)
- STARVE_MAX, 4, max consecutive high-QoS pops while low-QoS is waiting (≥1)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- in_vld  in  1  upstream packet valid
- in_rdy  out  1  buffer can accept a packet
- in_qos  in  1  packet QoS (1 = high)
- in_type  in  2  packet type (opaque, carried through)
- in_src  in  ID_W  source node ID
- in_tgt  in  ID_W  target node ID
- in_data  in  FLIT_W  payload
- out_vld  out  1  head packet valid
- out_rdy  in  1  downstream accepts head packet
- out_qos / out_type / out_src / out_tgt / out_data  out  1 / 2 / ID_W / ID_W / FLIT_W  head packet fields
- hi_cnt, lo_cnt  out  $clog2(DEPTH+1) each  queue occupancy

## Operation
- Push occurs on in_vld && in_rdy. The packet goes to the hi queue if in_qos=1, else to the lo queue.
- in_rdy = !rst && hi_cnt<DEPTH && lo_cnt<DEPTH.
  - It depends only on registered counts. It never depends on in_vld, in_qos, or out_rdy.
  - There is no same-cycle pass-through when a queue is full and popping.
- Pop occurs on out_vld && out_rdy, from the selected queue.
- Selection, evaluated only when not holding:
  - If hi is non-empty and the starvation counter < STARVE_MAX, select hi.
  - Else if lo is non-empty, select lo.
  - Else if hi is non-empty, select hi.
- Hold rule: when out_vld && !out_rdy, the selected queue and all out_* fields are frozen. This holds even if new packets arrive in either queue. A hold flag is registered on this condition and cleared on handshake.
- Starvation counter:
  - Increments on each hi pop while lo is non-empty, saturating at STARVE_MAX.
  - Clears on a lo pop, or whenever lo is empty.
- out_qos reflects the stored packet's QoS, i.e. the queue it came from.
- out_* payload fields are driven 0 when out_vld=0.
- Push and pop in the same cycle are legal on the same or different queues. Counts update by +1−1 accordingly.

## Timing
- Reset values: in_rdy=0 while rst is high; out_vld=0; payload outputs=0; hi_cnt=lo_cnt=0; starvation counter=0; hold=0. in_rdy rises the first cycle after rst deasserts.
- Latency: a packet pushed in cycle N appears on out_* in cycle N+1 at the earliest. There is no combinational bypass from in_* to out_*.
- Throughput: one push and one pop per cycle sustained.
- Occupancy counts are registered and reflect pushes/pops from the previous cycle.
- Reset asserted mid-operation flushes both queues, the counter and hold on the next edge. out_vld=0 is held from that edge.
- Wrap-around: read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are decided from counts, not pointers.

## Structure
- Package pkt_pkg holds:
  - typedef pkt_t {qos, type[1:0], src[ID_W-1:0], tgt[ID_W-1:0], data[FLIT_W-1:0]}.
  - The QOS_HI/QOS_LO constants.
- Sub-module pkt_fifo: a synchronous FIFO of pkt_t, parameter DEPTH, with push/pop/head/count ports. It is instantiated twice (hi, lo).
- The arbitration, hold and starvation logic lives in pkt_in_buf.

## Test plan
- Reset then single push (qos=0, src=3, tgt=9, data=8'hA5) in cycle 0 -> out_vld=1 in cycle 1 with identical fields; lo_cnt=1 until pop.
- With out_rdy=0, push 4 lo packets -> lo_cnt=4, in_rdy=0 next cycle. A 5th in_vld is not accepted. Assert out_rdy -> in_rdy returns the cycle after the first pop.
- With out_rdy=0, present a lo packet, then push a hi packet -> out_* stays on the lo packet (hold). Release out_rdy -> lo pops first, then hi.
- With out_rdy=1 and STARVE_MAX=4, preload 4 hi + 2 lo, then keep pushing hi every cycle -> pop order is 4 hi, 1 lo, 4 hi, 1 lo.
- Sustained alternating push/pop on a single queue for 20 packets -> no bubbles after the first; data order is preserved across pointer wrap.
- Assert rst for one cycle while hi_cnt=2 and lo_cnt=3 -> next cycle out_vld=0, counts=0; in_rdy=1 the cycle after rst deasserts.
